// File: rtl/usb_hid_kbd_events.sv
// Boot-protocol keyboard report differ: turns report-to-report changes into
// press/release events (modifiers mapped to usages 0xE0-0xE7) queued in a show-ahead FIFO.
module usb_hid_kbd_events #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset_i,
    input  logic [63:0]      usb_report_i,
    input  logic             usb_report_valid_i,
    output logic [8:0]       event_o,
    output logic             event_valid_o,
    input  logic             event_ready_i,
    output logic [CNT_W-1:0] count_o,
    output logic             overflow_o,
    input  logic             overflow_clr_i,
    output logic             busy_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);

    typedef enum logic [2:0] {S_IDLE, S_CHECK, S_MOD, S_REL, S_PRS, S_COMMIT} state_t;

    state_t      state_q, state_d;
    logic [2:0]  idx_q, idx_d;
    logic [63:0] cur_q, cur_d, prev_q, prev_d, pend_q, pend_d;
    logic        pend_vld_q, pend_vld_d;
    logic        push;
    logic [8:0]  push_data;
    logic [7:0]  cur_mod, prev_mod, key;
    int unsigned slot_j;

    logic [8:0]       mem_q [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q, count_d;
    logic             overflow_q, overflow_d;
    logic             pop, full, accept, drop;

    function automatic logic [7:0] slot(input logic [63:0] r, input int unsigned k);
        return r[8*k +: 8];
    endfunction

    function automatic logic has_key(input logic [63:0] r, input logic [7:0] k);
        logic hit;
        hit = 1'b0;
        for (int unsigned s = 2; s < 8; s++) begin
            if (slot(r, s) == k) hit = 1'b1;
        end
        return hit;
    endfunction

    // Only the first occurrence of a repeated keycode within a report yields an event.
    function automatic logic dup_before(input logic [63:0] r, input int unsigned j);
        logic hit;
        hit = 1'b0;
        for (int unsigned s = 2; s < 8; s++) begin
            if (s < j && slot(r, s) == slot(r, j)) hit = 1'b1;
        end
        return hit;
    endfunction

    assign cur_mod  = cur_q[7:0];
    assign prev_mod = prev_q[7:0];

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cur_d      = cur_q;
        prev_d     = prev_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        push       = 1'b0;
        push_data  = '0;
        slot_j     = 32'(idx_q) + 32'd2;
        key        = '0;

        if (usb_report_valid_i) pend_d = usb_report_i;

        case (state_q)
            S_IDLE: begin
                if (pend_vld_q) begin
                    cur_d      = pend_q;
                    pend_vld_d = usb_report_valid_i;
                    state_d    = S_CHECK;
                end else if (usb_report_valid_i) begin
                    cur_d   = usb_report_i;
                    state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (usb_report_valid_i) pend_vld_d = 1'b1;
                idx_d = '0;
                if (has_key(cur_q, 8'h01) ||
                    (cur_q[63:16] == prev_q[63:16] && cur_mod == prev_mod)) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_MOD;
                end
            end
            S_MOD: begin
                if (usb_report_valid_i) pend_vld_d = 1'b1;
                if (cur_mod[idx_q] != prev_mod[idx_q]) begin
                    push      = 1'b1;
                    push_data = {prev_mod[idx_q], 8'hE0 | {5'b0, idx_q}};
                end
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd7) state_d = S_REL;
            end
            S_REL: begin
                if (usb_report_valid_i) pend_vld_d = 1'b1;
                key = slot(prev_q, slot_j);
                if (key != 8'h00 && !has_key(cur_q, key) && !dup_before(prev_q, slot_j)) begin
                    push      = 1'b1;
                    push_data = {1'b1, key};
                end
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd5) begin
                    idx_d   = '0;
                    state_d = S_PRS;
                end
            end
            S_PRS: begin
                if (usb_report_valid_i) pend_vld_d = 1'b1;
                key = slot(cur_q, slot_j);
                if (key != 8'h00 && !has_key(prev_q, key) && !dup_before(cur_q, slot_j)) begin
                    push      = 1'b1;
                    push_data = {1'b0, key};
                end
                idx_d = idx_q + 3'd1;
                if (idx_q == 3'd5) state_d = S_COMMIT;
            end
            S_COMMIT: begin
                if (usb_report_valid_i) pend_vld_d = 1'b1;
                prev_d  = cur_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign pop    = (count_q != '0) && event_ready_i;
    assign full   = (count_q == CNT_W'(FIFO_DEPTH));
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_comb begin
        count_d = count_q;
        case ({accept, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        overflow_d = overflow_q;
        if (drop) overflow_d = 1'b1;
        else if (overflow_clr_i) overflow_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            cur_q      <= '0;
            prev_q     <= '0;
            pend_q     <= '0;
            pend_vld_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            cur_q      <= cur_d;
            prev_q     <= prev_d;
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (accept) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)    rd_ptr_q <= rd_ptr_q + AW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (accept) mem_q[wr_ptr_q] <= push_data;
    end

    // Storage is not reset, so the head is masked while the FIFO is empty.
    assign event_o       = (count_q != '0) ? mem_q[rd_ptr_q] : '0;
    assign event_valid_o = (count_q != '0);
    assign count_o       = count_q;
    assign overflow_o    = overflow_q;
    assign busy_o        = (state_q != S_IDLE);
endmodule

// File: tb/tb_usb_hid_kbd_events.sv
// Self-checking bench: directed scenarios plus randomized reports against a set-based event model.
module tb_usb_hid_kbd_events;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset_i = 1'b1;
    logic [63:0]   usb_report_i = '0;
    logic          usb_report_valid_i = 1'b0;
    logic [8:0]    event_o;
    logic          event_valid_o;
    logic          event_ready_i = 1'b0;
    logic [CW-1:0] count_o;
    logic          overflow_o;
    logic          overflow_clr_i = 1'b0;
    logic          busy_o;

    usb_hid_kbd_events #(.FIFO_DEPTH(DEPTH), .CNT_W(CW)) dut (
        .clk(clk), .reset_i(reset_i),
        .usb_report_i(usb_report_i), .usb_report_valid_i(usb_report_valid_i),
        .event_o(event_o), .event_valid_o(event_valid_o), .event_ready_i(event_ready_i),
        .count_o(count_o), .overflow_o(overflow_o), .overflow_clr_i(overflow_clr_i),
        .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  tmp_q[$];
    logic [8:0]  got_q[$];
    logic [63:0] model_prev = '0;
    bit          model_rollover;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rpt(input logic [7:0] m, input logic [7:0] k2 = 8'h00,
                                        input logic [7:0] k3 = 8'h00, input logic [7:0] k4 = 8'h00,
                                        input logic [7:0] k5 = 8'h00, input logic [7:0] k6 = 8'h00,
                                        input logic [7:0] k7 = 8'h00);
        return {k7, k6, k5, k4, k3, k2, 8'h00, m};
    endfunction

    // Expected events as set differences between the two reports' key sets.
    task automatic build_exp(input logic [63:0] p, input logic [63:0] c);
        bit [255:0] pset, cset, seen;
        logic [7:0] k;
        exp_q.delete();
        pset = '0; cset = '0;
        model_rollover = 1'b0;
        for (int j = 2; j < 8; j++) begin
            pset[p[8*j +: 8]] = 1'b1;
            cset[c[8*j +: 8]] = 1'b1;
            if (c[8*j +: 8] == 8'h01) model_rollover = 1'b1;
        end
        if (model_rollover) return;
        for (int b = 0; b < 8; b++)
            if (p[b] != c[b]) exp_q.push_back({p[b], 8'(8'hE0 + b)});
        seen = '0;
        for (int j = 2; j < 8; j++) begin
            k = p[8*j +: 8];
            if (k != 8'h00 && !cset[k] && !seen[k]) exp_q.push_back({1'b1, k});
            seen[k] = 1'b1;
        end
        seen = '0;
        for (int j = 2; j < 8; j++) begin
            k = c[8*j +: 8];
            if (k != 8'h00 && !pset[k] && !seen[k]) exp_q.push_back({1'b0, k});
            seen[k] = 1'b1;
        end
    endtask

    task automatic send(input logic [63:0] r);
        @(negedge clk);
        usb_report_i = r;
        usb_report_valid_i = 1'b1;
        @(negedge clk);
        usb_report_valid_i = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int quiet = 0;
        for (int i = 0; i < 300 && quiet < 3; i++) begin
            @(negedge clk);
            quiet = busy_o ? 0 : quiet + 1;
        end
        if (quiet < 3) begin
            checks++;
            errors++;
            $error("FAIL %s_timeout observed=busy expected=idle", tag);
        end
    endtask

    task automatic drain(input string tag);
        check({tag, "_count"}, 32'(count_o), exp_q.size());
        foreach (exp_q[i]) begin
            check($sformatf("%s_ev%0d", tag, i), {event_valid_o, event_o}, {1'b1, exp_q[i]});
            event_ready_i = 1'b1;
            @(negedge clk);
            event_ready_i = 1'b0;
        end
        check({tag, "_empty_valid"}, 32'(event_valid_o), 0);
        check({tag, "_empty_count"}, 32'(count_o), 0);
    endtask

    task automatic run_scan(input logic [63:0] r, input string tag);
        int n;
        build_exp(model_prev, r);
        send(r);
        wait_idle(tag);
        n = exp_q.size();
        check({tag, "_ovf"}, 32'(overflow_o), 32'(n > DEPTH));
        while (exp_q.size() > DEPTH) void'(exp_q.pop_back());
        if (!model_rollover) model_prev = r;
        drain(tag);
        @(negedge clk);
        overflow_clr_i = 1'b1;
        @(negedge clk);
        overflow_clr_i = 1'b0;
        check({tag, "_ovf_clr"}, 32'(overflow_o), 0);
    endtask

    function automatic logic [7:0] rkey();
        int unsigned r = $urandom_range(0, 15);
        if (r < 6) return 8'h00;
        if (r == 6) return ($urandom_range(0, 3) == 0) ? 8'h01 : 8'h04;
        return 8'(8'h04 + (r % 6));
    endfunction

    initial begin
        logic [63:0] r;
        bool_done: begin end

        repeat (3) @(negedge clk);
        check("rst_valid", 32'(event_valid_o), 0);
        check("rst_event", 32'(event_o), 0);
        check("rst_count", 32'(count_o), 0);
        check("rst_ovf", 32'(overflow_o), 0);
        check("rst_busy", 32'(busy_o), 0);
        reset_i = 1'b0;

        run_scan(rpt(8'h00, 8'h04), "press_a");
        run_scan(rpt(8'h00), "release_a");
        run_scan(rpt(8'h02, 8'h04), "mod_then_key");

        // identical report: only the CHECK cycle is busy
        send(rpt(8'h02, 8'h04));
        check("same_busy_check", 32'(busy_o), 1);
        @(negedge clk);
        check("same_busy_after", 32'(busy_o), 0);
        check("same_count", 32'(count_o), 0);

        run_scan(rpt(8'h00, 8'h05, 8'h01), "rollover");
        run_scan(rpt(8'h00, 8'h05), "after_rollover");

        // latency of the first modifier push
        build_exp(model_prev, rpt(8'h01, 8'h05));
        send(rpt(8'h01, 8'h05));
        @(negedge clk);
        check("lat_n2_valid", 32'(event_valid_o), 0);
        @(negedge clk);
        check("lat_n3_valid", 32'(event_valid_o), 1);
        check("lat_n3_event", 32'(event_o), 32'h0E0);
        wait_idle("lat");
        model_prev = rpt(8'h01, 8'h05);
        drain("lat");

        run_scan(rpt(8'h00), "clear_all");
        run_scan(rpt(8'h00, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15), "overflow");

        // full FIFO with a pop in the same cycle still accepts the push
        build_exp(model_prev, rpt(8'h00));
        send(rpt(8'h00));
        got_q.delete();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (!event_ready_i && count_o == CW'(DEPTH)) event_ready_i = 1'b1;
            if (event_ready_i && event_valid_o) got_q.push_back(event_o);
            if (event_ready_i && !event_valid_o && !busy_o) break;
        end
        event_ready_i = 1'b0;
        check("pushpop_n", got_q.size(), exp_q.size());
        foreach (exp_q[i])
            if (i < got_q.size()) check($sformatf("pushpop_ev%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
        check("pushpop_ovf", 32'(overflow_o), 0);
        model_prev = rpt(8'h00);

        // three strobes two cycles apart: the middle one is overwritten in the pending slot
        build_exp(model_prev, rpt(8'h00, 8'h20));
        tmp_q = exp_q;
        build_exp(rpt(8'h00, 8'h20), rpt(8'h00, 8'h22));
        exp_q = {tmp_q, exp_q};
        @(negedge clk); usb_report_i = rpt(8'h00, 8'h20); usb_report_valid_i = 1'b1;
        @(negedge clk); usb_report_valid_i = 1'b0;
        @(negedge clk); usb_report_i = rpt(8'h00, 8'h21); usb_report_valid_i = 1'b1;
        @(negedge clk); usb_report_valid_i = 1'b0;
        @(negedge clk); usb_report_i = rpt(8'h00, 8'h22); usb_report_valid_i = 1'b1;
        @(negedge clk); usb_report_valid_i = 1'b0;
        wait_idle("pending");
        drain("pending");
        model_prev = rpt(8'h00, 8'h22);

        // reset while releases are being pushed
        send(rpt(8'h00));
        repeat (10) @(negedge clk);
        reset_i = 1'b1;
        #1;
        check("midrst_valid", 32'(event_valid_o), 0);
        check("midrst_event", 32'(event_o), 0);
        check("midrst_count", 32'(count_o), 0);
        check("midrst_busy", 32'(busy_o), 0);
        @(negedge clk);
        reset_i = 1'b0;
        model_prev = '0;
        run_scan(rpt(8'h00, 8'h30, 8'h31), "post_reset");

        for (int it = 0; it < 40; it++) begin
            r[7:0]  = ($urandom_range(0, 1) == 0) ? model_prev[7:0] : 8'($urandom);
            r[15:8] = 8'($urandom);
            for (int j = 2; j < 8; j++) r[8*j +: 8] = rkey();
            run_scan(r, $sformatf("rnd%0d", it));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/usb_hid_kbd_events.md
Name: usb_hid_kbd_events

Overview:
- Sits between the USB HID host (boot-protocol keyboard report output) and the SoC keyboard register interface.
- Compares each new 8-byte report against the previous accepted report and emits one press/release event per changed key into a show-ahead FIFO that the CPU pops.
- Modifier bits are converted to HID usages 0xE0-0xE7, so all keys share one event format.

Parameters:
- FIFO_DEPTH, 16, event FIFO entries; power of 2, minimum 4.
- CNT_W, $clog2(FIFO_DEPTH)+1, width of count_o.

Ports:
- clk  in  1  system clock.
- reset_i  in  1  reset, asynchronous, active-high.
- usb_report_i  in  64  report; byte i = bits [8i+7:8i]; byte0 = modifiers, byte1 = reserved, bytes2-7 = keycodes (0 = empty slot).
- usb_report_valid_i  in  1  one-cycle strobe, already synchronous to clk.
- event_o  out  9  FIFO head: bit8 = release (1) / press (0), bits[7:0] = HID usage.
- event_valid_o  out  1  FIFO non-empty.
- event_ready_i  in  1  pop head when event_valid_o is high.
- count_o  out  CNT_W  FIFO occupancy.
- overflow_o  out  1  sticky: an event was discarded because the FIFO was full.
- overflow_clr_i  in  1  clears overflow_o.
- busy_o  out  1  scan in progress.

Behaviour:
- Reset (async assert, sync deassert by the upstream reset logic):
  - FIFO empty; prev report = all zero; pending slot empty.
  - FSM = IDLE; all outputs 0; event_o = 0.
- Capture:
  - In IDLE, a strobe latches usb_report_i into cur; next cycle FSM = CHECK.
  - A strobe outside IDLE goes to a single pending slot; a later strobe overwrites it (newest wins).
  - IDLE with pending full loads cur from pending the same cycle and clears the slot.
  - A strobe in the same cycle as the pending drain: the new strobe is stored in pending.
- FSM: IDLE -> CHECK -> MOD (8 cycles) -> REL (6) -> PRS (6) -> COMMIT -> IDLE.
- CHECK:
  - If any cur keycode byte equals 0x01 (ErrorRollOver), discard the report, keep prev, go to IDLE.
  - If cur == prev (byte1 ignored), go to IDLE with no events.
- MOD, bit b = 0..7: if cur[b] != prev[b], push {prev[b], 0xE0+b}. Bit 1 set in cur only gives press 0xE1; bit 1 set in prev only gives release 0xE1.
- REL, slot j = 2..7:
  - If prev[j] != 0 and prev[j] is not in any cur slot, push {1, prev[j]}.
  - Skip if prev[j] equals any prev slot < j (dedupe).
- PRS, slot j = 2..7:
  - If cur[j] != 0 and cur[j] is not in any prev slot, push {0, cur[j]}.
  - Same dedupe rule within cur.
- COMMIT: prev <= cur.
- busy_o is high in CHECK through COMMIT. Full scan = 22 cycles from strobe to IDLE.
- Event order is always modifiers (bit 0 first), then releases, then presses, in slot order.
- Latency: a push in the cycle after CHECK appears on event_o/event_valid_o on the following cycle (strobe at N gives valid at N+3).
- FIFO:
  - Show-ahead. Pop when event_valid_o && event_ready_i.
  - Push is accepted if count < FIFO_DEPTH, or if full with a pop in the same cycle.
  - Otherwise the push is dropped and overflow_o is set.
  - Pointers wrap modulo FIFO_DEPTH; count_o is exact.
  - Simultaneous push+pop on empty: the push is accepted, the pop is ignored (valid was low).
- overflow_clr_i: clears overflow_o. If a drop occurs in the same cycle, overflow_o stays set.
- Reset mid-scan: scan abandoned, prev zeroed, FIFO flushed. No partial events survive.

Test Plan:
- Report byte2=0x04 from reset -> single event 0x004 at N+3, count_o=1; pop -> valid low, count_o=0.
- Then all-zero report -> single event 0x104 (release 'A').
- Report byte0=0x02, byte2=0x04 after empty -> events 0x0E1 then 0x004, in that order.
- Same report twice -> second produces no events, busy_o high for exactly 1 cycle (CHECK). Report with byte3=0x01 -> no events and prev unchanged (next identical valid report is still diffed against the old prev).
- FIFO_DEPTH=4, no pops, 6 new keys pressed in one report -> count_o=4, overflow_o=1, events 0x0xx for slots 2-5 only; overflow_clr_i -> 0.
- Three strobes at N, N+2, N+4 -> report N scanned, then report N+4 scanned (N+2 lost). Assert reset_i during REL -> outputs 0 immediately; a following press report yields only press events.
